// File: rtl/ddr4_fine_sweep.sv
// DDR4 PHY fine-delay sweep: steps a shared tap, scores per-lane reads,
// and reports each lane's longest passing window to the training FSM.
module ddr4_fine_sweep #(
  parameter int LANES              = 16,
  parameter int DELAY_TAPS         = 64,
  parameter int SAMPLES_PER_TAP    = 8,
  parameter int PASS_THRESHOLD     = 7,
  parameter int SETTLE_CYCLES      = 4,
  parameter int MIN_WINDOW         = 6,
  parameter int MIN_LANES_REQUIRED = 12,
  localparam int TW = $clog2(DELAY_TAPS),
  localparam int WW = $clog2(DELAY_TAPS + 1),
  localparam int PW = $clog2(SAMPLES_PER_TAP + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fine_start,
  input  logic [LANES-1:0] read_ok,
  output logic [TW-1:0]    sweep_tap,
  output logic             busy,
  output logic             fine_done,
  output logic             fine_failed,
  output logic [LANES-1:0] lane_valid,
  output logic [TW-1:0]    best_start [0:LANES-1],
  output logic [TW-1:0]    best_end   [0:LANES-1],
  output logic [WW-1:0]    best_width [0:LANES-1]
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int VW = $clog2(LANES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET,
    S_SETTLE,
    S_SAMPLE,
    S_EVAL,
    S_REPORT
  } state_t;

  state_t state;
  logic start_q;
  logic start;
  logic in_sweep;

  logic [CW-1:0] settle_cnt;
  logic [PW-1:0] samp_cnt;
  logic [PW-1:0] pass_cnt  [LANES];
  logic [WW-1:0] cur_len   [LANES];
  logic [TW-1:0] cur_start [LANES];
  logic [WW-1:0] new_len   [LANES];
  logic [TW-1:0] run_start [LANES];

  logic [LANES-1:0] tap_good;
  logic [LANES-1:0] valid_nxt;
  logic [VW-1:0]    valid_cnt;

  assign start = fine_start & ~start_q;
  assign busy  = (state != S_IDLE);

  // Requester dropping fine_start during the sweep proper aborts it.
  assign in_sweep = (state == S_SET) || (state == S_SETTLE) ||
                    (state == S_SAMPLE) || (state == S_EVAL);

  always_comb begin
    valid_cnt = '0;
    for (int l = 0; l < LANES; l++) begin
      tap_good[l]  = pass_cnt[l] >= PW'(PASS_THRESHOLD);
      new_len[l]   = cur_len[l] + WW'(1);
      run_start[l] = (cur_len[l] == '0) ? sweep_tap : cur_start[l];
      valid_nxt[l] = best_width[l] >= WW'(MIN_WINDOW);
      valid_cnt    = valid_cnt + VW'(valid_nxt[l]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      start_q     <= 1'b0;
      settle_cnt  <= '0;
      samp_cnt    <= '0;
      sweep_tap   <= '0;
      fine_done   <= 1'b0;
      fine_failed <= 1'b0;
      lane_valid  <= '0;
      for (int l = 0; l < LANES; l++) begin
        best_start[l] <= '0;
        best_end[l]   <= '0;
        best_width[l] <= '0;
        cur_len[l]    <= '0;
        cur_start[l]  <= '0;
        pass_cnt[l]   <= '0;
      end
    end else begin
      start_q     <= fine_start;
      fine_done   <= 1'b0;
      fine_failed <= 1'b0;
      if (in_sweep && !fine_start) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              sweep_tap  <= '0;
              lane_valid <= '0;
              for (int l = 0; l < LANES; l++) begin
                best_start[l] <= '0;
                best_end[l]   <= '0;
                best_width[l] <= '0;
                cur_len[l]    <= '0;
                cur_start[l]  <= '0;
                pass_cnt[l]   <= '0;
              end
              state <= S_SET;
            end
          end
          S_SET: begin
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end
          S_SETTLE: begin
            settle_cnt <= settle_cnt + CW'(1);
            if (settle_cnt == CW'(SETTLE_CYCLES - 1)) begin
              samp_cnt <= '0;
              for (int l = 0; l < LANES; l++)
                pass_cnt[l] <= '0;
              state <= S_SAMPLE;
            end
          end
          S_SAMPLE: begin
            samp_cnt <= samp_cnt + PW'(1);
            for (int l = 0; l < LANES; l++)
              pass_cnt[l] <= pass_cnt[l] + PW'(read_ok[l]);
            if (samp_cnt == PW'(SAMPLES_PER_TAP - 1))
              state <= S_EVAL;
          end
          S_EVAL: begin
            for (int l = 0; l < LANES; l++) begin
              if (tap_good[l]) begin
                cur_len[l]   <= new_len[l];
                cur_start[l] <= run_start[l];
                // Strict compare keeps the earliest of equal windows.
                if (new_len[l] > best_width[l]) begin
                  best_start[l] <= run_start[l];
                  best_end[l]   <= sweep_tap;
                  best_width[l] <= new_len[l];
                end
              end else begin
                cur_len[l] <= '0;
              end
            end
            if (sweep_tap == TW'(DELAY_TAPS - 1)) begin
              state <= S_REPORT;
            end else begin
              sweep_tap <= sweep_tap + TW'(1);
              state     <= S_SET;
            end
          end
          S_REPORT: begin
            lane_valid  <= valid_nxt;
            fine_done   <= valid_cnt >= VW'(MIN_LANES_REQUIRED);
            fine_failed <= valid_cnt < VW'(MIN_LANES_REQUIRED);
            state       <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr4_fine_sweep.sv
// Randomized bench for ddr4_fine_sweep against a window-search model
// that scans every candidate start tap for its passing run.
module tb_ddr4_fine_sweep;

  localparam int L   = 16;
  localparam int T   = 64;
  localparam int S   = 8;
  localparam int TH  = 7;
  localparam int MW  = 6;
  localparam int ML  = 12;
  localparam int TC  = 14;
  localparam int REP = 1 + T * TC;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fine_start;
  logic [L-1:0]  read_ok;
  logic [5:0]    sweep_tap;
  logic          busy;
  logic          fine_done;
  logic          fine_failed;
  logic [L-1:0]  lane_valid;
  logic [5:0]    best_start [0:L-1];
  logic [5:0]    best_end   [0:L-1];
  logic [6:0]    best_width [0:L-1];

  ddr4_fine_sweep dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fine_start  (fine_start),
    .read_ok     (read_ok),
    .sweep_tap   (sweep_tap),
    .busy        (busy),
    .fine_done   (fine_done),
    .fine_failed (fine_failed),
    .lane_valid  (lane_valid),
    .best_start  (best_start),
    .best_end    (best_end),
    .best_width  (best_width)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  int pcnt [L][T];
  int e_start [L];
  int e_end   [L];
  int e_width [L];
  logic [L-1:0] e_valid;
  logic e_done;

  int o_pulses, o_pulse_at, o_both, o_busy_err, o_tap_err;
  logic o_done, o_failed;
  logic [L-1:0] o_valid;
  int o_start [L];
  int o_end   [L];
  int o_width [L];

  function automatic void model();
    int vc = 0;
    for (int l = 0; l < L; l++) begin
      e_start[l] = 0;
      e_end[l]   = 0;
      e_width[l] = 0;
      for (int s = 0; s < T; s++) begin
        int e = s;
        while (e < T && pcnt[l][e] >= TH) e++;
        if (e - s > e_width[l]) begin
          e_width[l] = e - s;
          e_start[l] = s;
          e_end[l]   = e - 1;
        end
      end
      e_valid[l] = (e_width[l] >= MW);
      if (e_valid[l]) vc++;
    end
    e_done = (vc >= ML);
  endfunction

  function automatic void fill_bad();
    for (int l = 0; l < L; l++)
      for (int t = 0; t < T; t++)
        pcnt[l][t] = $urandom_range(0, TH - 1);
  endfunction

  function automatic void set_good(int l, int lo, int hi);
    for (int t = lo; t <= hi; t++)
      pcnt[l][t] = $urandom_range(TH, S);
  endfunction

  task automatic sweep(input int abort_at, input bit hold);
    int rot [L];
    int ph, tp, s;
    bit eb;
    o_pulses = 0; o_pulse_at = -1; o_both = 0;
    o_busy_err = 0; o_tap_err = 0;
    o_done = 1'b0; o_failed = 1'b0;
    @(negedge clk); fine_start = 1'b0;
    @(negedge clk); fine_start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= REP + 3; i++) begin
      #1;
      if (i == abort_at) fine_start = 1'b0;
      ph = (i - 1) % TC;
      tp = (i - 1) / TC;
      if (i < REP && ph >= 5 && ph < 5 + S) begin
        s = ph - 5;
        for (int l = 0; l < L; l++) begin
          if (s == 0) rot[l] = $urandom_range(0, S - 1);
          read_ok[l] = (((s + rot[l]) % S) < pcnt[l][tp]);
        end
      end else begin
        read_ok = L'($urandom);
      end
      @(negedge clk);
      eb = (abort_at > 0) ? (i <= abort_at) : (i <= REP);
      if (busy !== eb) o_busy_err++;
      if (eb && i < REP && sweep_tap !== 6'(tp)) o_tap_err++;
      if (fine_done !== 1'b0 || fine_failed !== 1'b0) begin
        o_pulses++;
        o_pulse_at = i;
        o_done = fine_done;
        o_failed = fine_failed;
      end
      if (fine_done === 1'b1 && fine_failed === 1'b1) o_both++;
      if (i == REP + 1 || (abort_at > 0 && i == REP + 3)) begin
        o_valid = lane_valid;
        for (int l = 0; l < L; l++) begin
          o_start[l] = best_start[l];
          o_end[l]   = best_end[l];
          o_width[l] = best_width[l];
        end
      end
      @(posedge clk);
    end
    #1;
    if (!hold) fine_start = 1'b0;
  endtask

  task automatic test_reset();
    int nz = 0;
    rst_n = 1'b0; fine_start = 1'b0; read_ok = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({sweep_tap, busy, fine_done, fine_failed} !== 9'd0)
      $display("FAIL reset ctrl: got tap=%0d busy=%b done=%b failed=%b, need all 0",
               sweep_tap, busy, fine_done, fine_failed);
    else passed++;
    for (int l = 0; l < L; l++)
      if (best_start[l] !== 0 || best_end[l] !== 0 || best_width[l] !== 0) nz++;
    total++;
    if (lane_valid !== '0 || nz !== 0)
      $display("FAIL reset results: got valid=%h nonzero_lanes=%0d, need 0/0",
               lane_valid, nz);
    else passed++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b0)
      $display("FAIL reset idle: got busy=%b, need 0", busy);
    else passed++;
  endtask

  task automatic test_all_pass();
    for (int l = 0; l < L; l++)
      for (int t = 0; t < T; t++) pcnt[l][t] = S;
    model();
    sweep(0, 0);
    total++;
    if (o_pulses !== 1 || o_pulse_at !== REP + 1 || o_done !== 1'b1)
      $display("FAIL all_pass pulse: got %0d pulses at %0d done=%b, need 1 at %0d done=1",
               o_pulses, o_pulse_at, o_done, REP + 1);
    else passed++;
    total++;
    if (o_valid !== 16'hFFFF || o_start[9] !== 0 || o_end[9] !== 63 ||
        o_width[9] !== 64)
      $display("FAIL all_pass lane9: got valid=%h %0d/%0d/%0d, need FFFF 0/63/64",
               o_valid, o_start[9], o_end[9], o_width[9]);
    else passed++;
    total++;
    if (o_busy_err !== 0 || o_tap_err !== 0 || o_both !== 0)
      $display("FAIL all_pass seq: got busy_err=%0d tap_err=%0d both=%0d, need 0",
               o_busy_err, o_tap_err, o_both);
    else passed++;
    for (int l = 0; l < L; l++) begin
      total++;
      if (o_width[l] !== e_width[l] || o_start[l] !== e_start[l] ||
          o_end[l] !== e_end[l])
        $display("FAIL all_pass lane%0d: got %0d/%0d/%0d, need %0d/%0d/%0d", l,
                 o_start[l], o_end[l], o_width[l], e_start[l], e_end[l], e_width[l]);
      else passed++;
    end
  endtask

  task automatic test_two_windows();
    fill_bad();
    set_good(0, 10, 30);
    for (int l = 1; l < L; l++) set_good(l, 20, 40);
    model();
    sweep(0, 0);
    total++;
    if (o_start[0] !== 10 || o_end[0] !== 30 || o_width[0] !== 21)
      $display("FAIL two_win lane0: got %0d/%0d/%0d, need 10/30/21",
               o_start[0], o_end[0], o_width[0]);
    else passed++;
    total++;
    if (o_start[7] !== 20 || o_end[7] !== 40 || o_width[7] !== 21)
      $display("FAIL two_win lane7: got %0d/%0d/%0d, need 20/40/21",
               o_start[7], o_end[7], o_width[7]);
    else passed++;
    total++;
    if (o_pulses !== 1 || o_pulse_at !== REP + 1 || o_done !== e_done ||
        o_failed !== !e_done)
      $display("FAIL two_win verdict: got %0d@%0d done=%b failed=%b, need 1@%0d done=%b",
               o_pulses, o_pulse_at, o_done, o_failed, REP + 1, e_done);
    else passed++;
  endtask

  task automatic test_tie_fail();
    int bad = 0;
    fill_bad();
    for (int l = 0; l < L; l++) begin
      if (l < 5) begin
        set_good(l, 5, 9);
        set_good(l, 40, 44);
      end else begin
        set_good(l, 20, 40);
      end
    end
    model();
    sweep(0, 0);
    total++;
    if (o_start[3] !== 5 || o_end[3] !== 9 || o_width[3] !== 5 || o_valid[3] !== 1'b0)
      $display("FAIL tie lane3: got %0d/%0d/%0d v=%b, need 5/9/5 v=0",
               o_start[3], o_end[3], o_width[3], o_valid[3]);
    else passed++;
    total++;
    if (o_valid !== 16'hFFE0 || o_pulses !== 1 || o_failed !== 1'b1 ||
        o_done !== 1'b0 || o_pulse_at !== REP + 1)
      $display("FAIL tie verdict: got valid=%h pulses=%0d failed=%b done=%b at %0d, need FFE0 1 1 0 at %0d",
               o_valid, o_pulses, o_failed, o_done, o_pulse_at, REP + 1);
    else passed++;
    for (int l = 0; l < L; l++)
      if (o_width[l] !== e_width[l] || o_start[l] !== e_start[l] ||
          o_end[l] !== e_end[l]) bad++;
    total++;
    if (bad !== 0 || o_both !== 0)
      $display("FAIL tie lanes: got %0d bad lanes both=%0d, need 0/0", bad, o_both);
    else passed++;
  endtask

  task automatic test_threshold();
    fill_bad();
    for (int l = 0; l < L; l++) set_good(l, 10, 30);
    for (int t = 10; t <= 30; t++) pcnt[1][t] = TH;
    pcnt[1][9]  = TH - 1;
    pcnt[1][31] = TH - 1;
    pcnt[2][20] = TH - 1;
    model();
    sweep(0, 0);
    total++;
    if (o_start[1] !== 10 || o_end[1] !== 30 || o_width[1] !== 21)
      $display("FAIL thresh 7of8: got %0d/%0d/%0d, need 10/30/21",
               o_start[1], o_end[1], o_width[1]);
    else passed++;
    total++;
    if (o_start[2] !== 10 || o_end[2] !== 19 || o_width[2] !== 10)
      $display("FAIL thresh 6of8: got %0d/%0d/%0d, need 10/19/10",
               o_start[2], o_end[2], o_width[2]);
    else passed++;
    total++;
    if (o_valid !== e_valid || o_done !== e_done || o_pulse_at !== REP + 1)
      $display("FAIL thresh verdict: got valid=%h done=%b at %0d, need %h %b at %0d",
               o_valid, o_done, o_pulse_at, e_valid, e_done, REP + 1);
    else passed++;
  endtask

  task automatic test_random(input int iters);
    int lo, hi, bad;
    for (int n = 0; n < iters; n++) begin
      fill_bad();
      for (int l = 0; l < L; l++) begin
        repeat ($urandom_range(1, 3)) begin
          lo = $urandom_range(0, T - 1);
          hi = lo + $urandom_range(0, 24);
          if (hi > T - 1) hi = T - 1;
          set_good(l, lo, hi);
        end
      end
      model();
      sweep(0, 0);
      bad = 0;
      for (int l = 0; l < L; l++) begin
        total++;
        if (o_width[l] !== e_width[l] || o_start[l] !== e_start[l] ||
            o_end[l] !== e_end[l]) begin
          $display("FAIL random%0d lane%0d: got %0d/%0d/%0d, need %0d/%0d/%0d", n, l,
                   o_start[l], o_end[l], o_width[l], e_start[l], e_end[l], e_width[l]);
          bad++;
        end else passed++;
      end
      total++;
      if (o_valid !== e_valid || o_pulses !== 1 || o_done !== e_done ||
          o_failed !== !e_done || o_both !== 0 || o_busy_err !== 0 || o_tap_err !== 0)
        $display("FAIL random%0d verdict: got valid=%h p=%0d d=%b f=%b be=%0d te=%0d, need %h 1 %b",
                 n, o_valid, o_pulses, o_done, o_failed, o_busy_err, o_tap_err,
                 e_valid, e_done);
      else passed++;
    end
  endtask

  task automatic test_abort();
    for (int l = 0; l < L; l++)
      for (int t = 0; t < T; t++) pcnt[l][t] = S;
    sweep(300, 0);
    total++;
    if (o_busy_err !== 0 || o_tap_err !== 0)
      $display("FAIL abort busy: got busy_err=%0d tap_err=%0d, need 0/0",
               o_busy_err, o_tap_err);
    else passed++;
    total++;
    if (o_pulses !== 0 || o_valid !== '0)
      $display("FAIL abort pulse: got pulses=%0d valid=%h, need 0/0000",
               o_pulses, o_valid);
    else passed++;
    test_random(1);
  endtask

  task automatic test_hold_high();
    int extra_busy = 0;
    int extra_pulse = 0;
    fill_bad();
    for (int l = 0; l < L; l++) set_good(l, 3, 50);
    model();
    sweep(0, 1);
    total++;
    if (o_pulses !== 1 || o_done !== 1'b1 || o_width[4] !== 48)
      $display("FAIL hold first: got pulses=%0d done=%b width=%0d, need 1 1 48",
               o_pulses, o_done, o_width[4]);
    else passed++;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0) extra_busy++;
      if (fine_done !== 1'b0 || fine_failed !== 1'b0) extra_pulse++;
    end
    total++;
    if (extra_busy !== 0 || extra_pulse !== 0)
      $display("FAIL hold retrigger: got busy_cycles=%0d pulses=%0d, need 0/0",
               extra_busy, extra_pulse);
    else passed++;
    total++;
    if (lane_valid !== e_valid)
      $display("FAIL hold stable: got valid=%h, need %h", lane_valid, e_valid);
    else passed++;
    test_random(1);
  endtask

  task automatic test_reset_mid();
    int nz = 0;
    for (int l = 0; l < L; l++)
      for (int t = 0; t < T; t++) pcnt[l][t] = S;
    @(negedge clk); fine_start = 1'b0;
    @(negedge clk); fine_start = 1'b1;
    repeat (400) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int l = 0; l < L; l++)
      if (best_start[l] !== 0 || best_end[l] !== 0 || best_width[l] !== 0) nz++;
    total++;
    if ({sweep_tap, busy, fine_done, fine_failed} !== 9'd0 ||
        lane_valid !== '0 || nz !== 0)
      $display("FAIL reset_mid: got tap=%0d busy=%b valid=%h nonzero_lanes=%0d, need all 0",
               sweep_tap, busy, lane_valid, nz);
    else passed++;
    @(negedge clk);
    fine_start = 1'b0;
    rst_n = 1'b1;
    test_random(1);
  endtask

  initial begin
    rst_n = 1'b0;
    fine_start = 1'b0;
    read_ok = '0;
    test_reset();
    test_all_pass();
    test_two_windows();
    test_tie_fail();
    test_threshold();
    test_random(2);
    test_abort();
    test_hold_high();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ddr4_fine_sweep.md
# ddr4_fine_sweep

Fine-delay sweep engine for DDR4 PHY training: the responder behind the training FSM's `fine_start` / `fine_done` / `fine_failed` handshake. On each request it:
- steps a shared delay tap across every tap;
- samples per-lane read results at each tap;
- finds each lane's longest passing window.

It then reports per-lane window start, end and width, plus lane validity and a pass/fail verdict, back to the training FSM. It sits between the PHY delay-line and read-compare logic and the training FSM.

## Interface
- `LANES`, 16, number of byte/data lanes.
- `DELAY_TAPS`, 64, delay-line taps swept (0 … `DELAY_TAPS`-1).
- `SAMPLES_PER_TAP`, 8, `read_ok` samples taken per tap.
- `PASS_THRESHOLD`, 7, passes needed for a tap to count as good; must be ≤ `SAMPLES_PER_TAP`.
- `SETTLE_CYCLES`, 4, wait after each tap change before sampling.
- `MIN_WINDOW`, 6, minimum best width for a lane to be valid.
- `MIN_LANES_REQUIRED`, 12, minimum valid lanes for `fine_done`; otherwise `fine_failed`.
- Derived widths: TW = `$clog2(DELAY_TAPS)`, WW = `$clog2(DELAY_TAPS+1)`, PW = `$clog2(SAMPLES_PER_TAP+1)`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fine_start`  in  1  sweep request. A rising edge starts a sweep; it is held high by the requester while waiting.
- `read_ok`  in  LANES  per-lane read-compare pass for the current sample.
- `sweep_tap`  out  TW  delay tap applied to the PHY during the sweep.
- `busy`  out  1  high while a sweep is in progress.
- `fine_done`  out  1  one-cycle pulse: sweep complete, enough lanes valid.
- `fine_failed`  out  1  one-cycle pulse: sweep complete, too few valid lanes.
- `lane_valid`  out  LANES  lane best width ≥ `MIN_WINDOW`.
- `best_start`  out  TW × [0:LANES-1]  first tap of the lane's longest window.
- `best_end`  out  TW × [0:LANES-1]  last tap of that window.
- `best_width`  out  WW × [0:LANES-1]  window length in taps; 0 means no passing tap.

## Operation
- Registered `start_q` holds `fine_start` from the previous cycle.
- Start condition: `fine_start & ~start_q` while in IDLE.
- States:
  - **IDLE**: on start, clear every lane's `best_*`, `cur_len`, `pass_cnt` and `lane_valid`; set `sweep_tap`=0; go to SET.
  - **SET**: clear `settle_cnt`; go to SETTLE.
  - **SETTLE**: increment `settle_cnt`; when `settle_cnt`==`SETTLE_CYCLES`-1, clear `pass_cnt` and `samp_cnt`, go to SAMPLE. This state spends `SETTLE_CYCLES` cycles.
  - **SAMPLE**: per lane, `pass_cnt[l]` += `read_ok[l]`; increment `samp_cnt`. After `SAMPLES_PER_TAP` cycles, go to EVAL.
  - **EVAL**, for each lane, with tap good = `pass_cnt` ≥ `PASS_THRESHOLD`:
    - Good tap, `cur_len`==0: set `cur_start`=`sweep_tap`.
    - Good tap: `new_len`=`cur_len`+1. If `new_len` > `best_width`, set `best_start`=run start, `best_end`=`sweep_tap`, `best_width`=`new_len`. Use strict `>` so the earliest window wins a tie.
    - Bad tap: `cur_len`=0.
    - Then, if `sweep_tap`==`DELAY_TAPS`-1, go to REPORT; otherwise `sweep_tap`++ and go to SET.
  - **REPORT**:
    - Register `lane_valid[l]` = (`best_width[l]` ≥ `MIN_WINDOW`).
    - Count = popcount of that vector. Register `fine_done`=(count ≥ `MIN_LANES_REQUIRED`) and `fine_failed`=!`fine_done`.
    - Go to IDLE.
- `busy` = state ≠ IDLE.
- `best_*` and `lane_valid` hold their values from REPORT until the next start; they are stable when the done/failed pulse is seen.
- `sweep_tap` holds its last value in IDLE.
- Abort: `fine_start` sampled low in any state other than IDLE or REPORT returns to IDLE next cycle. No pulse is issued, `lane_valid` stays 0, and partial `best_*` are don't-care.
- A rising edge is only acted on in IDLE. A request still held high after completion does not retrigger; the requester must drop `fine_start` and raise it again.

## Timing
- Reset values: `sweep_tap`=0, `busy`=0, `fine_done`=0, `fine_failed`=0, `lane_valid`=0, all `best_start`/`best_end`/`best_width`=0; internal state IDLE, `start_q`=0.
- Reset mid-sweep forces all of the above immediately (asynchronous).
- Start edge sampled at posedge 0:
  - SET and `sweep_tap`=0 from cycle 1.
  - Each tap takes 1 + `SETTLE_CYCLES` + `SAMPLES_PER_TAP` + 1 cycles (14 with defaults).
  - REPORT occupies cycle 1 + `DELAY_TAPS`×14 = 897.
  - `fine_done`/`fine_failed` are high for exactly cycle 898 only, together with the updated `lane_valid`.
- `read_ok` is sampled only in SAMPLE cycles; values during SET, SETTLE and EVAL are ignored.
- Tie widths: `best_width` reaches `DELAY_TAPS` (all pass); WW holds it without wrap.
- `fine_done` and `fine_failed` are never high together.

## Test plan
- All lanes pass at every tap → `best_start`=0, `best_end`=63, `best_width`=64, `lane_valid`=16'hFFFF, `fine_done` pulse at cycle 898, one cycle wide.
- Lane 0 passes only at taps 10..30 and all others at 20..40 → lane 0 reports 10/30/21, others 20/40/21, `fine_done`.
- Lane 3 has windows 5..9 and 40..44 (equal width 5) → `best_start`=5, `best_end`=9, `best_width`=5, `lane_valid[3]`=0. With 5 lanes like this: 11 valid lanes, so `fine_failed` pulses and `fine_done` stays 0.
- Tap with exactly 7 of 8 passing samples counts as good; tap with 6 of 8 breaks the window.
- `fine_start` dropped at cycle 300 → `busy`=0 at cycle 301, no pulse, `lane_valid`=0. A new rising edge then yields a complete, correct sweep.
- `rst_n` asserted mid-sweep → all outputs 0 asynchronously. `fine_start` held high across the completion → no second sweep until it toggles.
